// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 32-source datapath bus, with a mandatory one-cycle
// turnaround (GAP) between owners. Optional hold-timeout is compiled in with ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] req,
  output logic [31:0] grant,
  output logic [4:0]  grant_idx,
  output logic        grant_valid,
  output logic        timeout,
  output logic [1:0]  state_dbg
);

  // Handshake: a source holds req high for as long as it wants the bus; once granted it keeps
  // the bus until it drops req (or is forcibly released), then the bus idles for one GAP cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  owner_q, owner_d;
  logic [4:0]  last_owner_q, last_owner_d;
  logic [31:0] grant_q, grant_d;
  logic [4:0]  grant_idx_q, grant_idx_d;
  logic        grant_valid_q, grant_valid_d;
  logic        force_release;
  logic        win_found;
  logic [4:0]  win_idx;
  logic [4:0]  cand;

  // First set request at or after last_owner+1, wrapping modulo 32.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < 32; i++) begin
      cand = last_owner_q + 5'd1 + 5'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          state_d      = GRANT;
          owner_d      = win_idx;
          last_owner_d = win_idx;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!req[owner_q] || force_release) begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet appear on entry.
  always_comb begin
    grant_d       = '0;
    grant_idx_d   = '0;
    grant_valid_d = 1'b0;
    if (state_d == GRANT) begin
      grant_d[owner_d] = 1'b1;
      grant_idx_d      = owner_d;
      grant_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_owner_q  <= 5'd31;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d, hold_inc;
  logic       timeout_q, timeout_d;

  // hold_inc counts GRANT cycles including the current one, saturating at 255.
  assign hold_inc      = (hold_q == 8'hFF) ? 8'hFF : hold_q + 8'd1;
  assign force_release = (state_q == GRANT) && (hold_inc >= 8'(MAX_HOLD));

  always_comb begin
    hold_d    = hold_q;
    timeout_d = force_release && req[owner_q];
    if (state_q != GRANT && state_d == GRANT) begin
      hold_d = '0;
    end else if (state_q == GRANT) begin
      hold_d = hold_inc;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_release = 1'b0;
  assign timeout       = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: reset, table vectors, hand sequences for wrap/timeout/async reset,
// then randomized requests against an ownership-level reference model.
module tb_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD  = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int HOLD  = 16;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clock;
  logic        clear;
  logic [31:0] req;
  logic [31:0] grant;
  logic [4:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;
  logic [1:0]  state_dbg;

  bus_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clock       (clock),
    .clear       (clear),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: {timeout, grant_valid, grant_idx, grant}
  logic [38:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: who owns the bus, who owned it last, how long the owner has held it.
  int m_owner;
  int m_last;
  int m_held;
  bit m_timeout;

  function automatic void model_reset();
    m_owner   = -1;
    m_last    = 31;
    m_held    = 0;
    m_timeout = 1'b0;
  endfunction

  function automatic void model_step(input logic [31:0] r);
    m_timeout = 1'b0;
    if (m_owner >= 0) begin
      if (m_held < 255) m_held++;
      if (!r[m_owner]) begin
        m_owner = -1;
      end else if (TO_EN && (m_held >= HOLD)) begin
        m_timeout = 1'b1;
        m_owner   = -1;
      end
    end else begin
      for (int k = 1; k <= 32; k++) begin
        int c;
        c = (m_last + k) % 32;
        if (r[c]) begin
          m_owner = c;
          m_last  = c;
          m_held  = 0;
          break;
        end
      end
    end
  endfunction

  function automatic logic [38:0] model_out();
    logic [31:0] g;
    logic [4:0]  idx;
    g   = '0;
    idx = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      idx        = 5'(m_owner);
    end
    return {m_timeout, (m_owner >= 0), idx, g};
  endfunction

  // Driver: advance one clock edge, then compare the outputs against the model.
  task automatic step();
    logic [38:0] e;
    if (clear) model_step(req);
    exp_q.push_back(model_out());
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("model", {timeout, grant_valid, grant_idx, grant}, e);
  endtask

  typedef struct {
    logic [31:0] req;
    logic [31:0] grant;
    logic [4:0]  idx;
    logic        valid;
  } vec_t;

  vec_t vecs[22];

  initial begin
    vecs[0]  = '{32'h0000_0020, 32'h0000_0020, 5'd5,  1'b1};
    vecs[1]  = '{32'h0000_0020, 32'h0000_0020, 5'd5,  1'b1};
    vecs[2]  = '{32'h0000_0020, 32'h0000_0020, 5'd5,  1'b1};
    vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0};
    vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0};
    vecs[5]  = '{32'h0000_0408, 32'h0000_0400, 5'd10, 1'b1};
    vecs[6]  = '{32'h0000_0008, 32'h0000_0000, 5'd0,  1'b0};
    vecs[7]  = '{32'h0000_0408, 32'h0000_0008, 5'd3,  1'b1};
    vecs[8]  = '{32'h0000_0400, 32'h0000_0000, 5'd0,  1'b0};
    vecs[9]  = '{32'h0000_0408, 32'h0000_0400, 5'd10, 1'b1};
    vecs[10] = '{32'h0000_0008, 32'h0000_0000, 5'd0,  1'b0};
    vecs[11] = '{32'h0000_0408, 32'h0000_0008, 5'd3,  1'b1};
    vecs[12] = '{32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0};
    vecs[13] = '{32'h0000_0001, 32'h0000_0001, 5'd0,  1'b1};
    vecs[14] = '{32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0};
    vecs[15] = '{32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0};
    vecs[16] = '{32'h8000_0000, 32'h8000_0000, 5'd31, 1'b1};
    vecs[17] = '{32'h4000_0001, 32'h0000_0000, 5'd0,  1'b0};
    vecs[18] = '{32'h4000_0001, 32'h0000_0001, 5'd0,  1'b1};
    vecs[19] = '{32'h4000_0000, 32'h0000_0000, 5'd0,  1'b0};
    vecs[20] = '{32'h4000_0000, 32'h4000_0000, 5'd30, 1'b1};
    vecs[21] = '{32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0};

    model_reset();
    clear = 1'b0;
    req   = 32'hFFFF_FFFF;
    #2;
    check("reset_async", 39'({timeout, grant_valid, grant_idx, grant}), 39'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("reset_hold", 39'({timeout, grant_valid, grant_idx, grant}), 39'd0);
    end
    clear = 1'b1;
    step();
    check("reset_first_grant", 39'({grant_valid, grant_idx, grant}), {7'd0, 1'b1, 5'd0, 32'h1});
    req = '0;
    step();
    step();

    for (int v = 0; v < 22; v++) begin
      req = vecs[v].req;
      step();
      check($sformatf("vec%0d", v), 39'({timeout, grant_valid, grant_idx, grant}),
            {1'b0, vecs[v].valid, vecs[v].idx, vecs[v].grant});
    end

    // Asynchronous reset mid-grant, then line 0 wins over 12 after release.
    req = 32'h0000_1000;
    step();
    check("amid_grant", 39'({grant_idx, grant}), 39'({5'd12, 32'h0000_1000}));
    #3;
    clear = 1'b0;
    model_reset();
    #1;
    check("amid_drop", 39'({timeout, grant_valid, grant_idx, grant}), 39'd0);
    step();
    req = 32'h0000_1001;
    #3;
    clear = 1'b1;
    step();
    check("amid_regrant", 39'({grant_idx, grant}), 39'({5'd0, 32'h0000_0001}));
    req = '0;
    step();
    step();

    // Long hold on line 7.
    req = 32'h0000_0080;
    for (int k = 0; k < 4; k++) begin
      step();
      check("hold_grant", 39'(grant), 39'(32'h80));
    end
`ifdef ARB_TIMEOUT_EN
    step();
    check("to_gap", 39'({timeout, grant_valid, grant}), 39'({1'b1, 1'b0, 32'h0}));
    step();
    check("to_regrant", 39'({timeout, grant_idx}), 39'({1'b0, 5'd7}));
    req = 32'h0000_0180;
    for (int k = 0; k < 3; k++) step();
    step();
    check("to_gap2", 39'({timeout, grant_valid}), 39'({1'b1, 1'b0}));
    step();
    check("to_next_owner", 39'({timeout, grant_idx, grant}), 39'({1'b0, 5'd8, 32'h100}));
`else
    for (int k = 0; k < 20; k++) begin
      step();
      check("hold_persist", 39'({timeout, grant_idx, grant}), 39'({1'b0, 5'd7, 32'h80}));
    end
`endif
    req = '0;
    step();
    step();

    // Randomized stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 4) == 0) req = '0;
        else req = $urandom & $urandom & $urandom;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
